// File: rtl/led_pattern_sequencer_if.sv
// ROM read port and LED driver load port shared by the pattern sequencer and its neighbours.
interface led_pattern_sequencer_if #(
    parameter int unsigned CH_NUM = 3,
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [CH_NUM-1:0] rom_data;
    logic [CH_NUM-1:0] pattern;
    logic              load_en;

    modport master (
        output rom_addr,
        output pattern,
        output load_en,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  pattern,
        input  load_en,
        output rom_data
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Plays a range of a synchronous pattern ROM onto the LED driver, holding each entry for a
// programmable number of tick strobes, with hold-at-end or loop playback and pause/stop control.
module led_pattern_sequencer #(
    parameter int unsigned CH_NUM = 3,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned TICK_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   pause,
    input  logic                   loop_mode,
    input  logic [ADDR_W-1:0]      first_addr,
    input  logic [ADDR_W-1:0]      last_addr,
    input  logic [TICK_W-1:0]      dwell,
    led_pattern_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done
);

    localparam logic [TICK_W-1:0] DwellOne = TICK_W'(1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StDwell,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [CH_NUM-1:0] pattern_q, pattern_d;
    logic              load_en_q, load_en_d;
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [TICK_W-1:0] dwell_q, dwell_d;
    logic              loop_q, loop_d;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        pattern_d  = pattern_q;
        load_en_d  = 1'b0;
        cnt_d      = cnt_q;
        first_d    = first_q;
        last_d     = last_q;
        dwell_d    = dwell_q;
        loop_d     = loop_q;

        if (stop) begin
            state_d    = StIdle;
            rom_addr_d = '0;
            pattern_d  = '0;
            cnt_d      = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        first_d    = first_addr;
                        last_d     = last_addr;
                        dwell_d    = (dwell == '0) ? DwellOne : dwell;
                        loop_d     = loop_mode;
                        rom_addr_d = first_addr;
                        state_d    = StFetch;
                    end
                end
                // ROM read latency: address went out on the previous edge.
                StFetch: state_d = StLatch;
                StLatch: begin
                    pattern_d = bus.rom_data;
                    load_en_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StDwell;
                end
                StDwell: begin
                    if (tick && !pause) begin
                        if (cnt_q == dwell_q - DwellOne) begin
                            if (rom_addr_q != last_q) begin
                                rom_addr_d = rom_addr_q + AddrOne;
                                state_d    = StFetch;
                            end else if (loop_q) begin
                                rom_addr_d = first_q;
                                state_d    = StFetch;
                            end else begin
                                state_d = StDone;
                            end
                        end else begin
                            cnt_d = cnt_q + DwellOne;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            pattern_q  <= '0;
            load_en_q  <= 1'b0;
            cnt_q      <= '0;
            first_q    <= '0;
            last_q     <= '0;
            dwell_q    <= '0;
            loop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            pattern_q  <= pattern_d;
            load_en_q  <= load_en_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            last_q     <= last_d;
            dwell_q    <= dwell_d;
            loop_q     <= loop_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.pattern  = pattern_q;
    assign bus.load_en  = load_en_q;
    assign busy         = (state_q == StFetch) || (state_q == StLatch) || (state_q == StDwell);
    assign done         = (state_q == StDone);

endmodule
